// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the streaming 3x3 convolution
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_t;

    // Pixel (zero-extended) times coefficient, summed over nine taps.
    function automatic int acc_width(input int data_w, input int coef_w);
        return data_w + coef_w + 5;
    endfunction

    // Sobel X kernel, row-major, loaded into every channel on reset.
    function automatic int sobel_x(input int idx);
        case (idx)
            0: return -1;
            2: return 1;
            3: return -2;
            5: return 2;
            6: return -1;
            8: return 1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - two cascaded one-row delay lines with enable-gated shift
module line_buffer #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 8,
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] tap1,
    output logic [DATA_WIDTH-1:0] tap2
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] line0_mem [DEPTH];
    logic [DATA_WIDTH-1:0] line1_mem [DEPTH];
    logic [PTR_W-1:0]      ptr_q;
    logic [PTR_W-1:0]      ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Circular storage: the slot read this cycle is the one overwritten, so it
    // holds the pixel one (line0) or two (line1) rows above the incoming one.
    always_ff @(posedge clk) begin
        if (en) begin
            line0_mem[ptr_q] <= din;
            line1_mem[ptr_q] <= line0_mem[ptr_q];
        end
    end

    assign tap1 = line0_mem[ptr_q];
    assign tap2 = line1_mem[ptr_q];

endmodule

// File: rtl/conv2d_stream.sv
// rtl/conv2d_stream.sv - streaming 3x3 valid convolution with P parallel kernels
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int P          = 2,
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COEF_WIDTH),
    localparam int CH_W      = (P > 1) ? $clog2(P) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abs_mode,
    input  logic                         kernel_wen,
    input  logic [CH_W-1:0]              kernel_ch,
    input  logic [3:0]                   kernel_addr,
    input  logic signed [COEF_WIDTH-1:0] kernel_in,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [P*ACC_WIDTH-1:0]       m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH + 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    conv_state_t                  state_q, state_d;
    logic [COL_W-1:0]             col_q, col_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic                         abs_q, abs_d;
    logic signed [COEF_WIDTH-1:0] coef_q [P][9];
    logic signed [COEF_WIDTH-1:0] coef_d [P][9];
    logic [DATA_WIDTH-1:0]        win_q [3][3];
    logic [DATA_WIDTH-1:0]        win_d [3][3];
    logic                         win_vld_q, win_vld_d;
    logic signed [PROD_W-1:0]     prod_q [P][9];
    logic signed [PROD_W-1:0]     prod_d [P][9];
    logic                         prod_vld_q, prod_vld_d;
    logic [P*ACC_WIDTH-1:0]       m_data_q, m_data_d;
    logic                         m_valid_q, m_valid_d;
    logic signed [ACC_WIDTH-1:0]  sum_c [P];

    logic [DATA_WIDTH-1:0] tap1, tap2;
    logic adv, accept, last_px, pipe_empty;

    // The whole pipeline moves together; a held output freezes every stage.
    assign adv        = !m_valid_q || m_ready;
    assign s_ready    = (state_q == ST_RUN) && adv;
    assign accept     = s_valid && s_ready;
    assign last_px    = accept && (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign pipe_empty = !win_vld_q && !prod_vld_q && !m_valid_q;

    line_buffer #(
        .DEPTH      (IMG_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line_buffer (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .din  (s_data),
        .tap1 (tap1),
        .tap2 (tap2)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (last_px) state_d = ST_DRAIN;
            ST_DRAIN: if (pipe_empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int p = 0; p < P; p++) begin
            logic signed [ACC_WIDTH-1:0] acc;
            acc = '0;
            for (int k = 0; k < 9; k++) begin
                acc = acc + {{(ACC_WIDTH-PROD_W){prod_q[p][k][PROD_W-1]}}, prod_q[p][k]};
            end
            sum_c[p] = acc;
        end
    end

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        abs_d      = abs_q;
        coef_d     = coef_q;
        win_d      = win_q;
        win_vld_d  = win_vld_q;
        prod_d     = prod_q;
        prod_vld_d = prod_vld_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;

        if (state_q == ST_IDLE && start) begin
            abs_d = abs_mode;
            col_d = '0;
            row_d = '0;
        end

        if (state_q == ST_IDLE && kernel_wen && int'(kernel_ch) < P && kernel_addr <= 4'd8) begin
            coef_d[kernel_ch][kernel_addr] = kernel_in;
        end

        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = tap2;
            win_d[1][2] = tap1;
            win_d[2][2] = s_data;
        end

        if (adv) begin
            win_vld_d  = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
            prod_vld_d = win_vld_q;
            m_valid_d  = prod_vld_q;
            for (int p = 0; p < P; p++) begin
                for (int k = 0; k < 9; k++) begin
                    prod_d[p][k] = $signed({1'b0, win_q[k/3][k%3]}) * coef_q[p][k];
                end
                m_data_d[p*ACC_WIDTH +: ACC_WIDTH] =
                    (abs_q && sum_c[p][ACC_WIDTH-1]) ? -sum_c[p] : sum_c[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            abs_q      <= 1'b0;
            win_vld_q  <= 1'b0;
            prod_vld_q <= 1'b0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            for (int p = 0; p < P; p++) begin
                for (int k = 0; k < 9; k++) begin
                    coef_q[p][k] <= COEF_WIDTH'(sobel_x(k));
                    prod_q[p][k] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            abs_q      <= abs_d;
            coef_q     <= coef_d;
            win_q      <= win_d;
            win_vld_q  <= win_vld_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv2d_stream.sv
// tb/tb_conv2d_stream.sv - self-checking bench for conv2d_stream
module tb_conv2d_stream;

    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int P    = 2;
    localparam int ACC  = DW + CW + 5;
    localparam int NPIX = W * H;
    localparam int NOUT = (W - 2) * (H - 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start, abs_mode, kernel_wen;
    logic [0:0]         kernel_ch;
    logic [3:0]         kernel_addr;
    logic [CW-1:0]      kernel_in;
    logic [DW-1:0]      s_data;
    logic               s_valid, s_ready;
    logic [P*ACC-1:0]   m_data;
    logic               m_valid, m_ready, busy, frame_done;

    conv2d_stream #(
        .DATA_WIDTH (DW),
        .COEF_WIDTH (CW),
        .IMG_W      (W),
        .IMG_H      (H),
        .P          (P)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abs_mode    (abs_mode),
        .kernel_wen  (kernel_wen),
        .kernel_ch   (kernel_ch),
        .kernel_addr (kernel_addr),
        .kernel_in   (kernel_in),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    int n_pass = 0;
    int n_total = 0;
    int kmodel [P][9];
    int pix [NPIX];
    int sobx [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int soby [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    logic [P*ACC-1:0] outs [$];

    typedef struct {
        int     pattern;
        bit     am;
        bit     load_y;
        longint exp0;
        longint exp1;
    } vec_t;
    vec_t vecs [4];

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic longint ch_val(input logic [P*ACC-1:0] d, input int p);
        logic signed [ACC-1:0] v;
        v = d[p*ACC +: ACC];
        return longint'(v);
    endfunction

    // Output at bottom-right corner (r, c) of its 3x3 neighbourhood.
    function automatic longint ref_val(input int r, input int c, input int p, input bit am);
        longint s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += longint'(kmodel[p][i*3+j]) * longint'(pix[(r-2+i)*W + (c-2+j)]);
        if (am && s < 0) s = -s;
        return s;
    endfunction

    task automatic model_sobel_x();
        for (int p = 0; p < P; p++)
            for (int k = 0; k < 9; k++)
                kmodel[p][k] = sobx[k];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; start = 0; kernel_wen = 0; s_valid = 0; m_ready = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        model_sobel_x();
    endtask

    task automatic write_kernel(input int ch, input int addr, input int val);
        kernel_wen = 1; kernel_ch = 1'(ch); kernel_addr = 4'(addr); kernel_in = CW'(val);
        @(negedge clk);
        kernel_wen = 0;
        if (ch < P && addr <= 8) kmodel[ch][addr] = val;
    endtask

    task automatic fill_pix(input int pattern);
        for (int i = 0; i < NPIX; i++) begin
            if (pattern == 0) pix[i] = i;
            else if (pattern == 1) pix[i] = NPIX - 1 - i;
            else pix[i] = int'($urandom_range(0, 255));
        end
    endtask

    task automatic run_frame(input bit am, input bit gaps, input bit bp, input bit stall5, input bit disturb);
        int idx = 0;
        int cyc = 0;
        int stall_left = 0;
        int fd_count = 0;
        bit stalled_done = 0;
        bit stall_ok = 1;
        bit seen_done = 0;
        logic [P*ACC-1:0] held = '0;
        outs.delete();
        @(negedge clk);
        start = 1; abs_mode = am;
        @(negedge clk);
        start = 0; abs_mode = ~am;
        #1 check("busy_after_start", longint'(busy), 1);
        while (!seen_done && cyc < 2000) begin
            if (stall5 && !stalled_done && m_valid && outs.size() >= 1) begin
                stall_left = 5; stalled_done = 1; held = m_data;
            end
            m_ready = !(bp && $urandom_range(0, 3) == 0) && (stall_left == 0);
            s_valid = (idx < NPIX) && !(gaps && $urandom_range(0, 2) == 0);
            s_data = (idx < NPIX) ? DW'(pix[idx]) : '0;
            kernel_wen = disturb && idx == 5; kernel_ch = 0; kernel_addr = 4; kernel_in = 8'd77;
            start = disturb && idx == 7;
            #1;
            if (stall_left > 0) begin
                if (s_ready !== 1'b0 || m_data !== held || m_valid !== 1'b1) stall_ok = 0;
                stall_left--;
            end
            if (s_valid && s_ready) idx++;
            if (m_valid && m_ready) outs.push_back(m_data);
            if (frame_done) begin fd_count++; seen_done = 1; end
            cyc++;
            @(negedge clk);
        end
        kernel_wen = 0; start = 0; s_valid = 0; m_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #1 if (frame_done) fd_count++;
            @(negedge clk);
        end
        check("frame_completed", longint'(seen_done), 1);
        check("pixels_accepted", idx, NPIX);
        check("frame_done_pulses", fd_count, 1);
        check("busy_after_frame", longint'(busy), 0);
        if (stall5) begin
            check("stall_triggered", longint'(stalled_done), 1);
            check("stall_hold", longint'(stall_ok), 1);
        end
    endtask

    task automatic check_model(input bit am);
        check("out_count", outs.size(), NOUT);
        for (int n = 0; n < outs.size() && n < NOUT; n++)
            for (int p = 0; p < P; p++)
                check($sformatf("model_ch%0d_out%0d", p, n), ch_val(outs[n], p),
                      ref_val(2 + n / (W - 2), 2 + n % (W - 2), p, am));
    endtask

    task automatic check_const(input int v, input longint e0, input longint e1);
        check($sformatf("vec%0d_count", v), outs.size(), NOUT);
        foreach (outs[n]) begin
            check($sformatf("vec%0d_ch0_out%0d", v, n), ch_val(outs[n], 0), e0);
            check($sformatf("vec%0d_ch1_out%0d", v, n), ch_val(outs[n], 1), e1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        rst = 1; start = 0; abs_mode = 0; kernel_wen = 0; kernel_ch = 0; kernel_addr = 0;
        kernel_in = 0; s_data = 0; s_valid = 0; m_ready = 1;
        do_reset();
        #1;
        check("rst_m_valid", longint'(m_valid), 0);
        check("rst_s_ready", longint'(s_ready), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_frame_done", longint'(frame_done), 0);
        check("rst_m_data", longint'(m_data), 0);

        vecs[0] = '{0, 1'b0, 1'b0, 8, 8};
        vecs[1] = '{0, 1'b0, 1'b1, 8, 32};
        vecs[2] = '{1, 1'b1, 1'b1, 8, 32};
        vecs[3] = '{1, 1'b0, 1'b1, -8, -32};
        for (int v = 0; v < 4; v++) begin
            if (vecs[v].load_y)
                for (int k = 0; k < 9; k++) write_kernel(1, k, soby[k]);
            fill_pix(vecs[v].pattern);
            run_frame(vecs[v].am, 1'b0, 1'b0, v == 1, v == 2);
            check_const(v, vecs[v].exp0, vecs[v].exp1);
        end

        for (int f = 0; f < 4; f++) begin
            bit am;
            for (int p = 0; p < P; p++)
                for (int k = 0; k < 9; k++)
                    write_kernel(p, k, int'($urandom_range(0, 255)) - 128);
            write_kernel(0, 9 + f, 99);
            fill_pix(2);
            am = 1'($urandom_range(0, 1));
            run_frame(am, 1'b1, 1'b1, f == 1, f == 2);
            check_model(am);
        end

        begin
            int idx = 0;
            int cyc = 0;
            bit quiet = 1;
            for (int k = 0; k < 9; k++) write_kernel(0, k, int'($urandom_range(0, 255)) - 128);
            fill_pix(2);
            start = 1; abs_mode = 0;
            @(negedge clk);
            start = 0;
            while (idx < 11 && cyc < 200) begin
                m_ready = 1; s_valid = 1; s_data = DW'(pix[idx]);
                #1 if (s_ready) idx++;
                cyc++;
                @(negedge clk);
            end
            check("rst_midframe_reached", idx, 11);
            s_valid = 0; rst = 1;
            @(negedge clk);
            rst = 0;
            model_sobel_x();
            for (int i = 0; i < 6; i++) begin
                #1 if (m_valid || busy || s_ready) quiet = 0;
                @(negedge clk);
            end
            check("rst_midframe_quiet", longint'(quiet), 1);
            fill_pix(2);
            run_frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            check_model(1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
